// File: rtl/spi_pkg.sv
// Shared types for the SPI master: controller states and the
// per-transfer mode bundle latched when a request is accepted.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } mode_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK timing: divider producing a tick every CLK_DIV cycles while
// running, and a saturating SCLK edge index during the data phase.
module spi_sclk_gen #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int EDGE_W  = $clog2(2 * DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              xfer,
    output logic              tick,
    output logic [EDGE_W-1:0] edge_idx,
    output logic              last_edge
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_MAX = EDGE_W'(2 * DATA_W - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick      = run && (div_cnt == DIV_MAX);
    assign last_edge = (edge_idx == EDGE_MAX);

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_MAX) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Phases share one divider so SETUP, XFER and HOLD stay aligned.
    always_ff @(posedge clk) begin
        if (reset || !xfer) begin
            edge_idx <= '0;
        end else if (tick && !last_edge) begin
            edge_idx <= edge_idx + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// Parametrised full-duplex SPI master: all four modes, MSB/LSB first,
// multiple slave selects, start/busy/done host handshake.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 1,
    parameter int CLK_DIV = 4,
    parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic [NUM_CS-1:0] cs_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int EDGE_W = $clog2(2 * DATA_W);

    state_t            state;
    state_t            state_nxt;
    mode_t             mode;
    logic [CS_W-1:0]   cs_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_ord;
    logic [DATA_W-1:0] rx_ord;
    logic [EDGE_W-1:0] edge_idx;
    logic              tick;
    logic              last_edge;
    logic              accept;
    logic              in_xfer;
    logic              leading;
    logic              shift_tx;
    logic              sample_rx;
    logic              finish;

    spi_sclk_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV),
        .EDGE_W  (EDGE_W)
    ) u_sclk_gen (
        .clk       (clk),
        .reset     (reset),
        .run       (state != IDLE),
        .xfer      (state == XFER),
        .tick      (tick),
        .edge_idx  (edge_idx),
        .last_edge (last_edge)
    );

    // The done cycle is already IDLE, so back-to-back starts are taken.
    assign accept  = start && (state == IDLE) && (32'(cs_sel) < NUM_CS);
    assign in_xfer = tick && (state == XFER);
    assign leading = ~edge_idx[0];
    assign finish  = tick && (state == HOLD);

    // Bit 0 is already on mosi before the first edge in both phases.
    assign shift_tx = in_xfer && (mode.cpha
                    ? (leading && (edge_idx != '0))
                    : (!leading && !last_edge));
    assign sample_rx = in_xfer && (leading ^ mode.cpha);

    // Shift registers always run MSB-first; reorder at the boundaries.
    always_comb begin
        tx_ord = tx_data;
        rx_ord = rx_sr;
        for (int i = 0; i < DATA_W; i++) begin
            tx_ord[i] = lsb_first ? tx_data[DATA_W-1-i] : tx_data[i];
            rx_ord[i] = mode.lsb_first ? rx_sr[DATA_W-1-i] : rx_sr[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cs_n      = '1;
        mosi      = 1'b0;
        unique case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   if (tick) state_nxt = XFER;
            XFER:    if (tick && last_edge) state_nxt = HOLD;
            HOLD:    if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE) begin
            cs_n = ~(NUM_CS'(1) << cs_q);
            mosi = tx_sr[DATA_W-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode    <= '0;
            cs_q    <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            rx_data <= '0;
            sclk    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                mode <= '{cpol: cpol, cpha: cpha, lsb_first: lsb_first};
                cs_q  <= cs_sel;
                tx_sr <= tx_ord;
                sclk  <= cpol;
                busy  <= 1'b1;
            end else begin
                if (done) busy <= 1'b0;
                if (in_xfer) sclk <= ~sclk;
                if (shift_tx) tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if (sample_rx) rx_sr <= {rx_sr[DATA_W-2:0], miso};
            if (finish) rx_data <= rx_ord;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: loopback and slave-model transfers
// in all modes, slave select decode, back-to-back, ignored starts, reset.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] cs_sel;
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic [3:0] cs_n;
    logic       sclk;
    logic       mosi;
    logic       miso;

    logic       start5;
    logic [2:0] cs_sel5;
    logic [7:0] rx5;
    logic       busy5;
    logic       done5;
    logic [4:0] cs_n5;
    logic       sclk5;
    logic       mosi5;

    logic       t_lb;
    logic       t_cpha;
    logic [7:0] s_word;
    logic [7:0] s_cap;
    logic       s_miso;
    logic       p_act;
    logic       p_sclk;
    int         s_idx;
    int         s_edge;

    int n_chk  = 0;
    int n_pass = 0;
    int lat;
    int rises;
    int cnt;

    always #5 clk = ~clk;

    assign miso = t_lb ? mosi : s_miso;

    spi_master_ctrl #(
        .DATA_W  (8),
        .NUM_CS  (4),
        .CLK_DIV (4)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cs_sel    (cs_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done),
        .cs_n      (cs_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso)
    );

    spi_master_ctrl #(
        .DATA_W  (8),
        .NUM_CS  (5),
        .CLK_DIV (4)
    ) u_dut5 (
        .clk       (clk),
        .reset     (reset),
        .start     (start5),
        .cs_sel    (cs_sel5),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .tx_data   (tx_data),
        .rx_data   (rx5),
        .busy      (busy5),
        .done      (done5),
        .cs_n      (cs_n5),
        .sclk      (sclk5),
        .mosi      (mosi5),
        .miso      (1'b0)
    );

    // Slave: drives s_word MSB-first, captures mosi on its sample edge.
    always @(negedge clk) begin
        logic act;
        logic lead;
        act = ~&cs_n;
        if (act && !p_act) begin
            s_idx  = 0;
            s_edge = 0;
            s_cap  = '0;
            s_miso = 1'b0;
            if (!t_cpha) begin
                s_miso = s_word[7];
                s_idx  = 1;
            end
        end else if (act && (sclk != p_sclk)) begin
            lead = (s_edge % 2) == 0;
            if (lead != t_cpha) begin
                s_cap = {s_cap[6:0], mosi};
            end else if (s_idx < 8) begin
                s_miso = s_word[7-s_idx];
                s_idx++;
            end
            s_edge++;
        end
        p_act  = act;
        p_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_done(input string tg, input int pulse_at,
                             input logic [3:0] exp_cs,
                             output int lat_o, output int rises_o);
        logic p;
        int   bad;
        p       = sclk;
        lat_o   = -1;
        rises_o = 0;
        bad     = 0;
        for (int n = 1; n <= 300; n++) begin
            if (pulse_at > 0 && n == pulse_at) begin
                start   = 1'b1;
                tx_data = 8'hFF;
            end
            if (pulse_at > 0 && n == pulse_at + 1) start = 1'b0;
            if (sclk && !p) rises_o++;
            p = sclk;
            if (done) begin
                lat_o = n;
                break;
            end
            if (cs_n != exp_cs) bad++;
            @(negedge clk);
        end
        check({tg, "_cs_hold"}, bad, 0);
    endtask

    task automatic do_xfer(input string tg, input logic [1:0] cs,
                           input logic pol, input logic pha,
                           input logic lsb, input logic [7:0] tx,
                           input int pulse_at,
                           output int lat_o, output int rises_o);
        logic [3:0] exp_cs;
        exp_cs    = ~(4'b0001 << cs);
        cs_sel    = cs;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        tx_data   = tx;
        t_cpha    = pha;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tg, "_c1_cs_n"}, cs_n, exp_cs);
        check({tg, "_c1_sclk"}, sclk, pol);
        check({tg, "_c1_busy"}, busy, 1);
        wait_done(tg, pulse_at, exp_cs, lat_o, rises_o);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        cs_sel    = '0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        lsb_first = 1'b0;
        tx_data   = '0;
        start5    = 1'b0;
        cs_sel5   = '0;
        t_lb      = 1'b0;
        t_cpha    = 1'b0;
        s_word    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rx", rx_data, 0);

        // Mode 0 loopback
        t_lb = 1'b1;
        do_xfer("t1", 2'd0, 1'b0, 1'b0, 1'b0, 8'hA5, 0, lat, rises);
        check("t1_lat", lat, 73);
        check("t1_rises", rises, 8);
        check("t1_rx", rx_data, 8'hA5);
        check("t1_mosi", s_cap, 8'hA5);
        check("t1_cs_off", cs_n, 4'hF);
        @(negedge clk);
        check("t1_busy_off", busy, 0);
        check("t1_done_pulse", done, 0);

        // Modes 1..3 against the slave model
        t_lb   = 1'b0;
        s_word = 8'h3C;
        for (int m = 1; m <= 3; m++) begin
            logic [1:0] md;
            md = 2'(m);
            do_xfer($sformatf("t2m%0d", m), 2'd0, md[1], md[0], 1'b0,
                    8'hC3, 0, lat, rises);
            check($sformatf("t2m%0d_lat", m), lat, 73);
            check($sformatf("t2m%0d_rises", m), rises, 8);
            check($sformatf("t2m%0d_rx", m), rx_data, 8'h3C);
            check($sformatf("t2m%0d_mosi", m), s_cap, 8'hC3);
            check($sformatf("t2m%0d_idle", m), sclk, md[1]);
            repeat (2) @(negedge clk);
            check($sformatf("t2m%0d_idle2", m), sclk, md[1]);
        end

        // LSB-first
        s_word = 8'h80;
        do_xfer("t3", 2'd0, 1'b0, 1'b0, 1'b1, 8'h01, 0, lat, rises);
        check("t3_lat", lat, 73);
        check("t3_rx", rx_data, 8'h01);
        check("t3_mosi", s_cap, 8'h80);
        @(negedge clk);

        // Slave select 2, then out-of-range select on the 5-slave unit
        t_lb = 1'b1;
        do_xfer("t4", 2'd2, 1'b0, 1'b0, 1'b0, 8'h96, 0, lat, rises);
        check("t4_lat", lat, 73);
        check("t4_rx", rx_data, 8'h96);
        @(negedge clk);
        cs_sel5 = 3'd5;
        start5  = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        cnt    = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy5 || done5 || (cs_n5 != 5'h1F)) cnt++;
            @(negedge clk);
        end
        check("t4_bad_sel_ignored", cnt, 0);
        check("t4_bad_sel_mosi", mosi5, 0);
        check("t4_bad_sel_rx", rx5, 0);
        cs_sel5 = 3'd4;
        start5  = 1'b1;
        @(negedge clk);
        start5 = 1'b0;
        check("t4_sel4_cs_n", cs_n5, 5'b01111);
        check("t4_sel4_busy", busy5, 1);

        // Start held through done: back-to-back with a 1-cycle gap
        cs_sel    = 2'd0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        lsb_first = 1'b0;
        t_cpha    = 1'b0;
        tx_data   = 8'h3A;
        start     = 1'b1;
        @(negedge clk);
        wait_done("t5a", 0, 4'hE, lat, rises);
        check("t5a_lat", lat, 73);
        check("t5a_rx", rx_data, 8'h3A);
        check("t5_gap_cs", cs_n, 4'hF);
        check("t5_gap_busy", busy, 1);
        tx_data = 8'hC5;
        @(negedge clk);
        start = 1'b0;
        check("t5b_cs_n", cs_n, 4'hE);
        check("t5b_busy", busy, 1);
        wait_done("t5b", 0, 4'hE, lat, rises);
        check("t5b_lat", lat, 73);
        check("t5b_rx", rx_data, 8'hC5);
        @(negedge clk);

        // Start pulsed mid-transfer is ignored
        do_xfer("t5c", 2'd0, 1'b0, 1'b0, 1'b0, 8'h6B, 30, lat, rises);
        check("t5c_lat", lat, 73);
        check("t5c_rx", rx_data, 8'h6B);
        @(negedge clk);
        check("t5c_busy_off", busy, 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy || (cs_n != 4'hF)) cnt++;
            @(negedge clk);
        end
        check("t5c_no_extra", cnt, 0);

        // Reset taken at SCLK edge 5 of a mode-3 transfer
        t_lb      = 1'b0;
        s_word    = 8'h3C;
        cs_sel    = 2'd0;
        cpol      = 1'b1;
        cpha      = 1'b1;
        lsb_first = 1'b0;
        t_cpha    = 1'b1;
        tx_data   = 8'h81;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (27) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_cs_n", cs_n, 4'hF);
        check("t6_sclk", sclk, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_mosi", mosi, 0);
        check("t6_rx", rx_data, 0);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            if (done || busy) cnt++;
            @(negedge clk);
        end
        check("t6_no_done", cnt, 0);
        t_lb = 1'b1;
        do_xfer("t6b", 2'd0, 1'b0, 1'b0, 1'b0, 8'h5A, 0, lat, rises);
        check("t6b_lat", lat, 73);
        check("t6b_rises", rises, 8);
        check("t6b_rx", rx_data, 8'h5A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
